// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state type.
// The receive-side checkers import the same line-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period edge counter for the UART transmitter.
// Pulses bit_done on the last clock of each bit period.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int Prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      run,
    input  logic [Prescale_width-1:0] prescale,
    output logic                      bit_done
);

    logic [Prescale_width-1:0] edge_cnt;
    logic [Prescale_width-1:0] last_cnt;

    // prescale is already forced nonzero by the framer
    assign last_cnt = prescale - 1'b1;
    assign bit_done = run && (edge_cnt == last_cnt);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            edge_cnt <= '0;
        end else if (bit_done) begin
            edge_cnt <= '0;
        end else if (run) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// TX_OUT and busy come straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [Prescale_width-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    tx_state_t                 state, state_n;
    logic                      tx_n, busy_n;
    logic [CW-1:0]             bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0]     data_reg;
    logic                      par_en_r, par_typ_r;
    logic [Prescale_width-1:0] presc_r, presc_in;
    logic                      accept, bit_done, par_bit;

    assign accept   = (state == IDLE) && Data_Valid;
    assign presc_in = (Prescale == '0) ? Prescale_width'(1) : Prescale;
    assign par_bit  = (^data_reg) ^ par_typ_r;

    uart_tx_bit_timer #(
        .Prescale_width(Prescale_width)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .run      (state != IDLE),
        .prescale (presc_r),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            TX_OUT  <= IDLE_LEVEL;
            busy    <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state   <= state_n;
            TX_OUT  <= tx_n;
            busy    <= busy_n;
            bit_cnt <= bit_cnt_n;
        end
    end

    // frame settings are captured only at the accept edge
    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg  <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= PAR_EVEN;
            presc_r   <= Prescale_width'(1);
        end else if (accept) begin
            data_reg  <= P_DATA;
            par_en_r  <= PAR_EN;
            par_typ_r <= PAR_TYP;
            presc_r   <= presc_in;
        end
    end

    // next TX_OUT is decoded one bit ahead so the pin is a flop
    always_comb begin
        state_n   = state;
        tx_n      = TX_OUT;
        busy_n    = busy;
        bit_cnt_n = bit_cnt;
        unique case (state)
            IDLE: begin
                tx_n = IDLE_LEVEL;
                if (Data_Valid) begin
                    state_n   = START;
                    tx_n      = START_BIT;
                    busy_n    = 1'b1;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    tx_n      = data_reg[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == LAST_BIT) begin
                        if (par_en_r) begin
                            state_n = PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = STOP_BIT;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = data_reg[bit_cnt_n];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                    tx_n    = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    tx_n    = IDLE_LEVEL;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
                tx_n    = IDLE_LEVEL;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame.
// Captures TX_OUT/busy per cycle and checks slot values against constants.
module tb_uart_tx_frame;

    logic       clk;
    logic       reset;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic txq [0:255];
    logic bq  [0:255];

    uart_tx_frame #(
        .DATA_WIDTH     (8),
        .Prescale_width (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d,
                               input logic pe,
                               input logic pt,
                               input logic [5:0] ps,
                               input bit hold);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = ps;
        Data_Valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) Data_Valid = 1'b0;
    endtask

    task automatic capture(input int n,
                           input int poke_at,
                           input int dv_off_at,
                           input int chg_at,
                           input logic [7:0] chg_data);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == poke_at) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
                Prescale   = 6'd16;
            end
            if (i == dv_off_at) Data_Valid = 1'b0;
            if (i == chg_at) P_DATA = chg_data;
            txq[i] = TX_OUT;
            bq[i]  = busy;
        end
    endtask

    task automatic check_frame(input string tag,
                               input int base,
                               input int nslots,
                               input int p,
                               input logic [15:0] exp);
        logic [15:0] obs;
        int errs;
        int bcnt;
        obs  = '0;
        errs = 0;
        bcnt = 0;
        for (int k = 0; k < nslots; k++) begin
            obs[k] = txq[base + k * p + p / 2];
        end
        for (int c = 0; c < nslots * p; c++) begin
            if (txq[base + c] !== exp[c / p]) errs++;
        end
        for (int c = 0; c <= nslots * p; c++) begin
            if (bq[base + c] === 1'b1) bcnt++;
        end
        check({tag, "_slots"}, 32'(obs), 32'(exp));
        check({tag, "_glitch"}, errs, 0);
        check({tag, "_busy"}, bcnt, nslots * p);
        check({tag, "_idle"},
              {30'd0, txq[base + nslots * p], bq[base + nslots * p]},
              32'b10);
    endtask

    initial begin
        int quiet;
        reset      = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 6'd8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 32'(TX_OUT), 1);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        start_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        capture(84, -1, -1, -1, 8'h00);
        check_frame("plain_a5", 0, 10, 8, 16'h034A);

        start_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
        capture(92, -1, -1, -1, 8'h00);
        check_frame("even_a5", 0, 11, 8, 16'h054A);

        start_frame(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0);
        capture(92, -1, -1, -1, 8'h00);
        check_frame("odd_a5", 0, 11, 8, 16'h074A);

        start_frame(8'h01, 1'b1, 1'b0, 6'd8, 1'b0);
        capture(92, -1, -1, -1, 8'h00);
        check_frame("even_01", 0, 11, 8, 16'h0602);

        start_frame(8'h3C, 1'b0, 1'b0, 6'd8, 1'b0);
        capture(100, 20, 30, -1, 8'h00);
        check_frame("ignore_3c", 0, 10, 8, 16'h0278);
        quiet = 0;
        for (int i = 80; i < 100; i++) begin
            if (txq[i] !== 1'b1 || bq[i] !== 1'b0) quiet++;
        end
        check("ignore_no_second", quiet, 0);
        Prescale = 6'd8;

        start_frame(8'h55, 1'b0, 1'b0, 6'd1, 1'b1);
        capture(30, -1, 12, 3, 8'hAA);
        check_frame("b2b_first", 0, 10, 1, 16'h02AA);
        check_frame("b2b_second", 11, 10, 1, 16'h0354);

        start_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
        capture(36, -1, -1, -1, 8'h00);
        check("rst_mid_bit3", 32'(txq[35]), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", 32'(TX_OUT), 1);
        check("rst_mid_busy", 32'(busy), 0);
        start_frame(8'h01, 1'b0, 1'b0, 6'd2, 1'b0);
        capture(24, -1, -1, -1, 8'h00);
        check_frame("after_rst", 0, 10, 2, 16'h0202);

        start_frame(8'hA5, 1'b0, 1'b0, 6'd0, 1'b0);
        capture(14, -1, -1, -1, 8'h00);
        check_frame("presc0", 0, 10, 1, 16'h034A);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
